// File: rtl/spi_slave_responder_if.sv
// SPI target bus bundle: external SPI pins plus the local TX/RX control and status.
// The slave modport is the responder's view; the master modport is the view of the SPI master and local logic.
`timescale 1ns/1ps
interface spi_slave_responder_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  CS;
  logic                  S_CLK;
  logic                  MOSI;
  logic                  MISO;
  logic                  MISO_OE;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_WRITE;
  logic                  TX_READY;
  logic [DATA_WIDTH-1:0] RX_DATA;
  logic                  RX_VALID;
  logic                  RX_ACK;
  logic                  RX_OVERRUN;
  logic                  TX_UNDERRUN;
  logic                  BUSY;

  modport slave (
    input  CS, S_CLK, MOSI, TX_DATA, TX_WRITE, RX_ACK,
    output MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, RX_OVERRUN, TX_UNDERRUN, BUSY
  );

  modport master (
    output CS, S_CLK, MOSI, TX_DATA, TX_WRITE, RX_ACK,
    input  MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, RX_OVERRUN, TX_UNDERRUN, BUSY
  );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI mode-0 target. S_CLK, CS and MOSI are oversampled in the CLK domain; MOSI is
// deserialised into RX words while a one-entry TX holding buffer is serialised onto MISO.
// Bit order: MSB first by default; define SPI_SLAVE_LSB_FIRST_EN for LSB first.
`timescale 1ns/1ps
module spi_slave_responder #(
  parameter int unsigned          DATA_WIDTH  = 8,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_FILL    = {DATA_WIDTH{1'b1}}
) (
  input  logic                  CLK,
  input  logic                  CLR,
  spi_slave_responder_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] s_clk_sync, cs_sync, mosi_sync;
  logic                   s_clk_d, cs_d;
  logic                   s_clk_s, cs_s, mosi_s;
  logic                   s_rise_c, s_fall_c, cs_fall_c;

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    reload_q;
  logic [DATA_WIDTH-1:0]   tx_sh, tx_buf, rx_data_q;
  logic [DATA_WIDTH-2:0]   rx_sh;
  logic                    miso_q, miso_oe_q, tx_ready_q, rx_valid_q;
  logic                    rx_overrun_q, tx_underrun_q, busy_q;

  logic [DATA_WIDTH-1:0]   load_word_c, tx_rot_c, rx_next_c;
  logic                    first_bit_c, next_bit_c;
  logic                    word_done_c, load_c, tx_accept_c;

  assign s_clk_s   = s_clk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign s_rise_c  = s_clk_s & ~s_clk_d;
  assign s_fall_c  = ~s_clk_s & s_clk_d;
  assign cs_fall_c = ~cs_s & cs_d;

  // Synchronise the SPI pins and keep one extra flop for edge detection
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      s_clk_sync <= '0;
      cs_sync    <= '1;
      mosi_sync  <= '0;
      s_clk_d    <= 1'b0;
      cs_d       <= 1'b1;
    end else begin
      s_clk_sync <= {s_clk_sync[SYNC_STAGES-2:0], bus.S_CLK};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], bus.CS};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
      s_clk_d    <= s_clk_s;
      cs_d       <= cs_s;
    end
  end

  // Bit-order dependent shift helpers; the TX register rotates so MISO is always taken from it
`ifdef SPI_SLAVE_LSB_FIRST_EN
  always_comb begin
    first_bit_c = load_word_c[0];
    tx_rot_c    = {tx_sh[0], tx_sh[DATA_WIDTH-1:1]};
    next_bit_c  = tx_rot_c[0];
    rx_next_c   = {mosi_s, rx_sh};
  end
`else
  always_comb begin
    first_bit_c = load_word_c[DATA_WIDTH-1];
    tx_rot_c    = {tx_sh[DATA_WIDTH-2:0], tx_sh[DATA_WIDTH-1]};
    next_bit_c  = tx_rot_c[DATA_WIDTH-1];
    rx_next_c   = {rx_sh, mosi_s};
  end
`endif

  // Word completion, TX register load events and TX buffer write acceptance
  always_comb begin
    load_word_c = tx_ready_q ? TX_FILL : tx_buf;
    word_done_c = (state == SHIFT) && !cs_s && s_rise_c &&
                  (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    load_c      = (state == LOAD) ||
                  ((state == SHIFT) && !cs_s && s_fall_c && reload_q);
    tx_accept_c = bus.TX_WRITE && tx_ready_q;
  end

  // Transfer FSM with TX buffer, RX status and registered outputs
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      reload_q      <= 1'b0;
      tx_sh         <= '0;
      tx_buf        <= '0;
      rx_sh         <= '0;
      rx_data_q     <= '0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      tx_ready_q    <= 1'b1;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      // A load drains the buffer; a write in the same cycle refills it afterwards
      if (load_c) tx_ready_q <= 1'b1;
      if (tx_accept_c) begin
        tx_buf        <= bus.TX_DATA;
        tx_ready_q    <= 1'b0;
        tx_underrun_q <= 1'b0;
      end
      if (load_c && tx_ready_q) tx_underrun_q <= 1'b1;

      if (word_done_c) begin
        rx_data_q  <= rx_next_c;
        rx_valid_q <= 1'b1;
        if (rx_valid_q && !bus.RX_ACK) rx_overrun_q <= 1'b1;
      end else if (bus.RX_ACK) begin
        rx_valid_q   <= 1'b0;
        rx_overrun_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cs_fall_c) begin
            state  <= LOAD;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          tx_sh     <= load_word_c;
          miso_q    <= first_bit_c;
          miso_oe_q <= 1'b1;
          rx_sh     <= '0;
          bit_cnt   <= '0;
          reload_q  <= 1'b0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (cs_s) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            bit_cnt   <= '0;
            reload_q  <= 1'b0;
          end else if (s_rise_c) begin
            rx_sh <= rx_next_c[DATA_WIDTH-2:0];
`ifdef SPI_SLAVE_LSB_FIRST_EN
            rx_sh <= rx_next_c[DATA_WIDTH-1:1];
`endif
            if (word_done_c) begin
              bit_cnt  <= '0;
              reload_q <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (s_fall_c) begin
            if (reload_q) begin
              tx_sh    <= load_word_c;
              miso_q   <= first_bit_c;
              reload_q <= 1'b0;
            end else begin
              tx_sh  <= tx_rot_c;
              miso_q <= next_bit_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MISO        = miso_q;
  assign bus.MISO_OE     = miso_oe_q;
  assign bus.TX_READY    = tx_ready_q;
  assign bus.RX_DATA     = rx_data_q;
  assign bus.RX_VALID    = rx_valid_q;
  assign bus.RX_OVERRUN  = rx_overrun_q;
  assign bus.TX_UNDERRUN = tx_underrun_q;
  assign bus.BUSY        = busy_q;
endmodule
